// File: rtl/powlib_ipmaxi.sv
// PLB-to-AXI4-Lite master bridge: turns PLB write/read opcodes into single
// AXI-Lite transactions, returning read data as a PLB write to a caller-given address.
module powlib_ipmaxi #(
  parameter int              B_BPD  = 4,
  parameter int              B_AW   = 32,
  parameter int              B_OPW  = 4,
  parameter logic [B_AW-1:0] B_BASE = 32'h44A20000,
  parameter logic [B_AW-1:0] M_BASE = 32'h40000000,
  parameter int              OP_WR  = 0,
  parameter int              OP_RD  = 1,
  parameter int              B_DW   = 8*B_BPD,
  parameter int              B_BEW  = B_BPD,
  parameter int              B_WW   = B_DW+B_BEW+B_OPW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [B_AW-1:0]   wraddr,
  input  logic [B_WW-1:0]   wrdata,
  input  logic              wrvld,
  output logic              wrrdy,
  output logic [B_AW-1:0]   rdaddr,
  output logic [B_WW-1:0]   rddata,
  output logic              rdvld,
  input  logic              rdrdy,
  output logic [B_AW-1:0]   awaddr,
  output logic              awvalid,
  input  logic              awready,
  output logic [B_DW-1:0]   wdata,
  output logic [B_BEW-1:0]  wstrb,
  output logic              wvalid,
  input  logic              wready,
  input  logic [1:0]        bresp,
  input  logic              bvalid,
  output logic              bready,
  output logic [B_AW-1:0]   araddr,
  output logic              arvalid,
  input  logic              arready,
  input  logic [B_DW-1:0]   rdata,
  input  logic [1:0]        rresp,
  input  logic              rvalid,
  output logic              rready,
  output logic              err
);

  localparam logic [B_OPW-1:0] OP_WR_W = B_OPW'(OP_WR);
  localparam logic [B_OPW-1:0] OP_RD_W = B_OPW'(OP_RD);

  typedef enum logic [2:0] {IDLE, WR, WB, AR, RD, RSP} state_t;

  state_t           state_q, state_d;
  logic             wrrdy_q, wrrdy_d;
  logic             awvalid_q, awvalid_d;
  logic             wvalid_q, wvalid_d;
  logic             bready_q, bready_d;
  logic             arvalid_q, arvalid_d;
  logic             rready_q, rready_d;
  logic             rdvld_q, rdvld_d;
  logic             err_q, err_d;
  logic [B_AW-1:0]  addr_q, addr_d;
  logic [B_AW-1:0]  ret_q, ret_d;
  logic [B_DW-1:0]  data_q, data_d;
  logic [B_BEW-1:0] be_q, be_d;
  logic [B_DW-1:0]  rdat_q, rdat_d;

  logic [B_OPW-1:0] req_op;
  assign req_op = wrdata[B_DW+B_BEW +: B_OPW];

  always_comb begin
    state_d   = state_q;
    wrrdy_d   = wrrdy_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    rdvld_d   = rdvld_q;
    err_d     = err_q;
    addr_d    = addr_q;
    ret_d     = ret_q;
    data_d    = data_q;
    be_d      = be_q;
    rdat_d    = rdat_q;
    case (state_q)
      IDLE: begin
        // wrrdy comes back one cycle after re-entering IDLE
        if (!wrrdy_q) begin
          wrrdy_d = 1'b1;
        end else if (wrvld) begin
          if (req_op == OP_WR_W || req_op == OP_RD_W) begin
            addr_d  = wraddr - B_BASE + M_BASE;
            ret_d   = wrdata[B_AW-1:0];
            data_d  = wrdata[0 +: B_DW];
            be_d    = wrdata[B_DW +: B_BEW];
            wrrdy_d = 1'b0;
            if (req_op == OP_WR_W) begin
              awvalid_d = 1'b1;
              wvalid_d  = 1'b1;
              state_d   = WR;
            end else begin
              state_d = AR;
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      WR: begin
        awvalid_d = awvalid_q & ~awready;
        wvalid_d  = wvalid_q & ~wready;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = WB;
        end
      end
      WB: begin
        if (bvalid) begin
          bready_d = 1'b0;
          if (bresp != 2'b00) err_d = 1'b1;
          state_d = IDLE;
        end
      end
      AR: begin
        if (!arvalid_q) begin
          arvalid_d = 1'b1;
        end else if (arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD;
        end
      end
      RD: begin
        if (rvalid) begin
          rready_d = 1'b0;
          rdat_d   = rdata;
          if (rresp != 2'b00) err_d = 1'b1;
          state_d = RSP;
        end
      end
      RSP: begin
        if (!rdvld_q) begin
          rdvld_d = 1'b1;
        end else if (rdrdy) begin
          rdvld_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      wrrdy_q   <= 1'b1;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      rdvld_q   <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      ret_q     <= '0;
      data_q    <= '0;
      be_q      <= '0;
      rdat_q    <= '0;
    end else begin
      state_q   <= state_d;
      wrrdy_q   <= wrrdy_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      rdvld_q   <= rdvld_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      ret_q     <= ret_d;
      data_q    <= data_d;
      be_q      <= be_d;
      rdat_q    <= rdat_d;
    end
  end

  assign wrrdy   = wrrdy_q;
  assign awaddr  = addr_q;
  assign araddr  = addr_q;
  assign awvalid = awvalid_q;
  assign wvalid  = wvalid_q;
  assign wdata   = data_q;
  assign wstrb   = be_q;
  assign bready  = bready_q;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;
  assign rdvld   = rdvld_q;
  assign rdaddr  = ret_q;
  assign rddata  = {OP_WR_W, {B_BEW{1'b1}}, rdat_q};
  assign err     = err_q;

endmodule

// File: tb/tb_powlib_ipmaxi.sv
// Directed bench for powlib_ipmaxi: writes, reads, skewed handshakes, errors,
// response backpressure, reset mid-transaction and an unknown opcode.
module tb_powlib_ipmaxi;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wraddr;
  logic [39:0] wrdata;
  logic        wrvld;
  logic        wrrdy;
  logic [31:0] rdaddr;
  logic [39:0] rddata;
  logic        rdvld;
  logic        rdrdy;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic        err;

  int errors = 0;
  int checks = 0;
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0, rsp_cnt = 0;

  powlib_ipmaxi dut (
    .clk(clk), .rst(rst),
    .wraddr(wraddr), .wrdata(wrdata), .wrvld(wrvld), .wrrdy(wrrdy),
    .rdaddr(rdaddr), .rddata(rddata), .rdvld(rdvld), .rdrdy(rdrdy),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (awvalid && awready) aw_cnt++;
    if (wvalid && wready)   w_cnt++;
    if (bvalid && bready)   b_cnt++;
    if (arvalid && arready) ar_cnt++;
    if (rvalid && rready)   r_cnt++;
    if (rdvld && rdrdy)     rsp_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request; it is accepted at the next edge (wrrdy assumed high).
  task automatic issue(input logic [31:0] a, input logic [3:0] op, input logic [3:0] be,
                       input logic [31:0] d);
    wraddr = a;
    wrdata = {op, be, d};
    wrvld  = 1'b1;
    tick();
    wrvld  = 1'b0;
  endtask

  task automatic wait_wrrdy(input string tag);
    int n;
    n = 0;
    while (!wrrdy && n < 30) begin
      tick();
      n++;
    end
    check(tag, wrrdy, 1'b1);
  endtask

  task automatic wait_rdvld(output int n);
    n = 1;
    while (!rdvld && n < 30) begin
      tick();
      n++;
    end
  endtask

  int n, a0, w0, b0, r0;

  initial begin
    rst = 1'b1;
    wraddr = '0; wrdata = '0; wrvld = 1'b0; rdrdy = 1'b0;
    awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;
    arready = 1'b0; rdata = '0; rresp = 2'b00; rvalid = 1'b0;
    #3;
    check("rst_wrrdy", wrrdy, 1'b1);
    check("rst_valids", {rdvld, awvalid, wvalid, bready, arvalid, rready}, 6'b0);
    check("rst_err", err, 1'b0);
    check("rst_addr", awaddr, 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // Plain write, every ready high
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
    a0 = aw_cnt; w0 = w_cnt;
    issue(32'h44A20010, 4'h0, 4'hF, 32'hDEADBEEF);
    check("wr_valids_c1", {awvalid, wvalid, wrrdy}, 3'b110);
    check("wr_awaddr", awaddr, 32'h40000010);
    check("wr_wdata", wdata, 32'hDEADBEEF);
    check("wr_wstrb", wstrb, 4'hF);
    tick();
    check("wr_bready_c2", {bready, awvalid, wvalid}, 3'b100);
    tick();
    check("wr_c3", {bready, wrrdy}, 2'b00);
    tick();
    check("wr_wrrdy_c4", wrrdy, 1'b1);
    check("wr_counts", {aw_cnt - a0, w_cnt - w0}, {32'd1, 32'd1});
    check("wr_err", err, 1'b0);
    bvalid = 1'b0;

    // Read, every ready high
    arready = 1'b1; rvalid = 1'b1; rdata = 32'h12345678; rresp = 2'b00;
    issue(32'h44A20004, 4'h1, 4'hF, 32'h50000020);
    check("rd_wrrdy_low", wrrdy, 1'b0);
    wait_rdvld(n);
    check("rd_latency", n, 5);
    check("rd_araddr", araddr, 32'h40000004);
    check("rd_rdaddr", rdaddr, 32'h50000020);
    check("rd_rddata", rddata, 40'h0F12345678);
    r0 = rsp_cnt;
    rdrdy = 1'b1;
    tick();
    rdrdy = 1'b0;
    check("rd_rsp_done", {rdvld, 32'(rsp_cnt - r0)}, {1'b0, 32'd1});
    wait_wrrdy("rd_wrrdy_back");
    rvalid = 1'b0;

    // Skewed write: W completes three cycles before AW
    awready = 1'b0; wready = 1'b0;
    a0 = aw_cnt; w0 = w_cnt; b0 = b_cnt;
    issue(32'h44A20020, 4'h0, 4'h5, 32'h01020304);
    wready = 1'b1;
    tick();
    check("sk_w_drop", {awvalid, wvalid}, 2'b10);
    tick();
    tick();
    check("sk_aw_hold", {awvalid, wvalid, bready}, 3'b100);
    awready = 1'b1;
    tick();
    check("sk_bready", {awvalid, bready}, 2'b01);
    check("sk_counts", {aw_cnt - a0, w_cnt - w0}, {32'd1, 32'd1});
    bvalid = 1'b1;
    tick();
    bvalid = 1'b0;
    tick();
    check("sk_bpulse", {bready, 32'(b_cnt - b0)}, {1'b0, 32'd1});
    wait_wrrdy("sk_wrrdy_back");

    // Error on write response, then on read response
    bvalid = 1'b1; bresp = 2'b10;
    issue(32'h44A20030, 4'h0, 4'hF, 32'hAAAA5555);
    wait_wrrdy("er_wr_done");
    check("er_after_bresp", err, 1'b1);
    bvalid = 1'b0; bresp = 2'b00;
    rvalid = 1'b1; rresp = 2'b11; rdata = 32'hCAFEF00D;
    issue(32'h44A20008, 4'h1, 4'h0, 32'h60000000);
    wait_rdvld(n);
    check("er_rdvld", rdvld, 1'b1);
    check("er_rddata", rddata, 40'h0FCAFEF00D);
    check("er_sticky", err, 1'b1);
    rdrdy = 1'b1;
    tick();
    rdrdy = 1'b0; rvalid = 1'b0; rresp = 2'b00;
    wait_wrrdy("er_rd_done");

    // Backpressure on the read response
    rvalid = 1'b1; rdata = 32'h0BADF00D;
    issue(32'h44A2000C, 4'h1, 4'hF, 32'h70000040);
    wait_rdvld(n);
    for (int i = 0; i < 10; i++) begin
      check("bp_hold", {rdvld, wrrdy, rdaddr, rddata}, {1'b1, 1'b0, 32'h70000040, 40'h0F0BADF00D});
      tick();
    end
    r0 = rsp_cnt;
    rdrdy = 1'b1;
    tick();
    rdrdy = 1'b0;
    tick();
    tick();
    check("bp_one_rsp", {rdvld, 32'(rsp_cnt - r0)}, {1'b0, 32'd1});
    rvalid = 1'b0;
    wait_wrrdy("bp_wrrdy_back");

    // Reset while stuck in WR
    awready = 1'b0; wready = 1'b0;
    issue(32'h44A20040, 4'h0, 4'hF, 32'h11111111);
    check("rm_in_wr", {awvalid, wvalid}, 2'b11);
    #2;
    rst = 1'b1;
    #1;
    check("rm_async_drop", {awvalid, wvalid}, 2'b00);
    tick();
    rst = 1'b0;
    tick();
    check("rm_wrrdy", {wrrdy, err}, 2'b10);
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1;
    a0 = aw_cnt;
    issue(32'h44A20FFC, 4'h0, 4'h3, 32'h000000A5);
    check("rm_awaddr", {awaddr, wdata, 28'h0, wstrb}, {32'h40000FFC, 32'h000000A5, 32'h3});
    wait_wrrdy("rm_wr_done");
    check("rm_one_aw", aw_cnt - a0, 1);
    check("rm_no_err", err, 1'b0);
    bvalid = 1'b0;

    // Unknown opcode is consumed and flagged
    a0 = aw_cnt; r0 = ar_cnt;
    issue(32'h44A20050, 4'h5, 4'hF, 32'h22222222);
    check("bo_state", {wrrdy, awvalid, arvalid, err}, 4'b1001);
    tick();
    check("bo_no_axi", {aw_cnt - a0, ar_cnt - r0}, {32'd0, 32'd0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/powlib_ipmaxi.md
Name: powlib_ipmaxi

Overview:
- Bridges the powlib packed bus (PLB) to an AXI4-Lite master port; the counterpart of powlib_ipsaxi.
- It is a crossbar slave: it accepts PLB write-requests carrying either a write or a read opcode, and issues the matching AXI-Lite transaction toward Xilinx IP.
- Read data returns as a PLB write to the requester-supplied return address.
- One transaction outstanding at a time.

Parameters:
- B_BPD, 4, bytes per data word; B_DW=8*B_BPD, B_BEW=B_BPD.
- B_AW, 32, PLB and AXI address width.
- B_OPW, 4, opcode width; packed word B_WW=B_DW+B_BEW+B_OPW.
- B_BASE, 32'h44A20000, PLB window base; subtracted from the incoming address.
- M_BASE, 32'h40000000, AXI base; added after the subtraction.
- OP_WR, 0, write opcode.
- OP_RD, 1, read opcode.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- wraddr  in  B_AW  incoming PLB address.
- wrdata  in  B_WW  packed {op,be,data}; data at [0+:B_DW], be at [B_DW+:B_BEW], op at [B_DW+B_BEW+:B_OPW].
- wrvld  in  1  request valid.
- wrrdy  out  1  request ready.
- rdaddr  out  B_AW  read-response return address.
- rddata  out  B_WW  read-response packed word.
- rdvld  out  1  response valid.
- rdrdy  in  1  response ready.
- awaddr  out  B_AW  AXI write address.
- awvalid  out  1  AXI write-address valid.
- awready  in  1  AXI write-address ready.
- wdata  out  B_DW  AXI write data.
- wstrb  out  B_BEW  AXI write strobes.
- wvalid  out  1  AXI write-data valid.
- wready  in  1  AXI write-data ready.
- bresp  in  2  AXI write response code.
- bvalid  in  1  AXI write response valid.
- bready  out  1  AXI write response ready.
- araddr  out  B_AW  AXI read address.
- arvalid  out  1  AXI read-address valid.
- arready  in  1  AXI read-address ready.
- rdata  in  B_DW  AXI read data.
- rresp  in  2  AXI read response code.
- rvalid  in  1  AXI read data valid.
- rready  out  1  AXI read data ready.
- err  out  1  sticky: any non-OKAY bresp/rresp seen.

Behaviour:
- Single clock clk. rst is asynchronous and active-high; it clears all state and forces state=IDLE.
- Reset values: wrrdy=1, rdvld=0, awvalid=0, wvalid=0, bready=0, arvalid=0, rready=0, err=0. Address and data outputs reset to 0.
- All outputs are registered.
- Handshakes: transfer on vld&rdy. Valids never drop before their ready. Payload is stable while valid is high.
- FSM states: IDLE, WR, WB, AR, RD, RSP.
- IDLE:
  - wrrdy=1.
  - On wrvld with op==OP_WR: latch address and payload; next state WR; wrrdy=0.
  - On wrvld with op==OP_RD: latch; next state AR.
  - On wrvld with any other op: consume the request and drop it; set err; stay in IDLE.
- Address computation: AXI address = wraddr - B_BASE + M_BASE, mod 2^B_AW. The low 2 bits pass through unchanged.
- WR:
  - awvalid and wvalid both assert the cycle after acceptance. wdata=data, wstrb=be.
  - Each valid deasserts independently on its own handshake; AW and W may complete in any order or in the same cycle.
  - When both have completed: next state WB, bready=1.
- WB: on bvalid, capture bresp; if non-zero, set err. Return to IDLE with wrrdy=1 the following cycle. Writes are posted: no PLB response.
- AR: arvalid=1 until arready, then RD with rready=1. The return address is the latched data field (low B_AW bits).
- RD: on rvalid, capture rdata; if rresp non-zero, set err. Next state RSP.
- RSP:
  - rdvld=1; rdaddr=return address; rddata={OP_WR, all-ones be, rdata}.
  - rdata is returned even on error.
  - On rdrdy: rdvld=0; return to IDLE.
- Minimum latencies (every ready already high):
  - Write: 4 cycles from wrvld accept to next wrrdy.
  - Read: 5 cycles from accept to rdvld.
- Boundary conditions:
  - Back-to-back requests are stalled by wrrdy=0.
  - rdrdy held low keeps the FSM in RSP indefinitely with the payload stable.
  - A reset mid-transaction abandons the AXI transfer and drops all valids the same instant (asynchronously).
  - bvalid or rvalid arriving outside WB/RD is ignored.

Test Plan:
- Write, all readies high: wraddr=0x44A20010, data=0xDEADBEEF, be=0xF, op=0. Required: awaddr=0x40000010, wdata=0xDEADBEEF, wstrb=0xF in cycle 1; bready then; wrrdy high again 4 cycles after accept; err=0.
- Read: wraddr=0x44A20004, op=1, data=0x50000020; AXI returns rdata=0x12345678, rresp=0. Required: araddr=0x40000004; rdaddr=0x50000020; rddata low word 0x12345678 with be=0xF and op=0.
- Skewed write: wready rises 3 cycles before awready. Required: wvalid drops after its handshake; awvalid holds until awready; exactly one AW and one W transfer; single bready pulse.
- Error: bresp=2'b10 on a write, then rresp=2'b11 on a read. Required: err=1 and stays 1; the read response is still delivered.
- Backpressure: rdrdy held low 10 cycles. Required: rdvld and the payload stay stable; wrrdy=0 throughout; on release, exactly one response is delivered.
- Reset mid-operation: assert rst while in WR with awready=0. Required: awvalid, wvalid=0 immediately; wrrdy=1 after reset; a following write completes normally.
